// File: rtl/param_bound_flasher.sv
// param_bound_flasher
//   Parametrised bound flasher. Drives an LED_W-wide thermometer bar through
//   a three-bounce fill/drain sequence that `flick` starts from IDLE.
//   Turn-around points come from LO_BOUND, MID_BOUND and LED_W. A prescaler
//   divides the step rate by STEP_DIV. Holding `flick` in the upper fill
//   phases at LO_BOUND or MID_BOUND sends the bar back down (kickback).
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   pause      in   1      (PAUSE_EN only) freezes stepping while high
//   flick      in   1      start / kickback request, level sampled
//   led_output out  LED_W  thermometer bar, bit i lit when i < cnt
//   state_o    out  3      current phase code (debug)
//   done       out  1      one-cycle pulse on return to IDLE
//
// Optional feature macro: PAUSE_EN (adds the `pause` input).

module param_bound_flasher #(
  parameter int LED_W     = 16,
  parameter int LO_BOUND  = 6,
  parameter int MID_BOUND = 11,
  parameter int STEP_DIV  = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PAUSE_EN
  input  logic             pause,
`endif
  input  logic             flick,
  output logic [LED_W-1:0] led_output,
  output logic [2:0]       state_o,
  output logic             done
);

  localparam int CNT_W = $clog2(LED_W + 1);
  localparam int PRE_W = $clog2(STEP_DIV + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(LO_BOUND);
  localparam logic [CNT_W-1:0] CNT_LOM1 = CNT_W'(LO_BOUND - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_BOUND);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(LED_W);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PRE_W-1:0] r_pre;
  logic [LED_W-1:0] r_led;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [LED_W-1:0] w_led_nxt;
  logic             w_done_nxt;
  logic             w_run;
  logic             w_tick;
  logic             w_step;
  logic             w_kick;

`ifdef PAUSE_EN
  assign w_run = ~pause;
`else
  assign w_run = 1'b1;
`endif

  assign w_tick = (r_pre == PRE_LAST);
  assign w_step = w_run & w_tick;
  // Kickback condition shared by both upper fill phases.
  assign w_kick = flick & ((r_cnt == CNT_LO) | (r_cnt == CNT_MID));

  // State, count and prescaler registers; the LED bar and done pulse are
  // registered from the next-state values so they change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_led   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pre   <= w_pre_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic. Outside IDLE everything holds between prescaler ticks;
  // the prescaler is forced to zero whenever the next state is IDLE so each
  // new sequence starts with a full step interval.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pre_nxt   = r_pre;
    w_done_nxt  = 1'b0;

    if (r_state != IDLE && w_run) begin
      w_pre_nxt = w_tick ? '0 : (r_pre + PRE_ONE);
    end

    case (r_state)
      IDLE: begin
        w_pre_nxt = '0;
        if (flick) begin
          w_state_nxt = UP1;
        end
      end
      UP1: begin
        if (w_step) begin
          if (r_cnt == CNT_LO) begin
            w_state_nxt = DN1;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      DN1: begin
        if (w_step) begin
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = UP2;
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      UP2: begin
        if (w_step) begin
          if (w_kick) begin
            w_state_nxt = DN1;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else if (r_cnt == CNT_MID) begin
            w_state_nxt = DN2;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      DN2: begin
        if (w_step) begin
          if (r_cnt == CNT_LOM1) begin
            w_state_nxt = UP3;
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      UP3: begin
        if (w_step) begin
          if (w_kick) begin
            w_state_nxt = DN2;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else if (r_cnt == CNT_TOP) begin
            w_state_nxt = DN3;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      DN3: begin
        if (w_step) begin
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      default: begin
        // Unused phase code: recover straight to an empty IDLE.
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_state_nxt == IDLE) begin
      w_pre_nxt = '0;
    end
  end

  // Thermometer decode of the next count.
  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < LED_W; i++) begin
      w_led_nxt[i] = (i < int'(w_cnt_nxt));
    end
  end

  assign led_output = r_led;
  assign state_o    = r_state;
  assign done       = r_done;

endmodule
